// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline-boundary register with valid/ready handshake, flush and exception masking.
// Define SKID_BUF_EN to add a second (skid) entry so up_ready is driven from a flop.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned KEEP_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cancel,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  input  logic              up_exc,
  input  logic              up_jbr,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  output logic              dn_exc,
  output logic              dn_delay,
  output logic [1:0]        occupancy
);

  logic              accept;
  logic              out_xfer;
  logic [DATA_W-1:0] in_data;
  logic              in_delay;

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic              main_exc_q, main_exc_d;
  logic              main_delay_q, main_delay_d;

  // On an upstream exception only the low KEEP_W bits (the PC) survive.
  always_comb begin
    in_data = up_data;
    if (up_exc) begin
      for (int unsigned i = 0; i < DATA_W; i++) begin
        if (i >= KEEP_W) in_data[i] = 1'b0;
      end
    end
  end

  assign in_delay = up_jbr & ~up_exc;
  assign out_xfer = main_valid_q & dn_ready;
  assign accept   = up_valid & up_ready;

  assign dn_valid = main_valid_q;
  assign dn_data  = main_data_q;
  assign dn_exc   = main_exc_q;
  assign dn_delay = main_delay_q;

`ifdef SKID_BUF_EN

  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              skid_exc_q, skid_exc_d;
  logic              skid_delay_q, skid_delay_d;

  assign up_ready  = ~skid_valid_q;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_exc_d   = main_exc_q;
    main_delay_d = main_delay_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_exc_d   = skid_exc_q;
    skid_delay_d = skid_delay_q;
    if (cancel) begin
      main_valid_d = 1'b0;
      main_data_d  = '0;
      main_exc_d   = 1'b0;
      main_delay_d = 1'b0;
      skid_valid_d = 1'b0;
      skid_data_d  = '0;
      skid_exc_d   = 1'b0;
      skid_delay_d = 1'b0;
    end else if (out_xfer) begin
      // Skid full implies up_ready=0, so no accept can coincide with the shift.
      if (skid_valid_q) begin
        main_data_d  = skid_data_q;
        main_exc_d   = skid_exc_q;
        main_delay_d = skid_delay_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_data_d  = in_data;
        main_exc_d   = up_exc;
        main_delay_d = in_delay;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (main_valid_q) begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
        skid_exc_d   = up_exc;
        skid_delay_d = in_delay;
      end else begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
        main_exc_d   = up_exc;
        main_delay_d = in_delay;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_exc_q   <= 1'b0;
      skid_delay_q <= 1'b0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_exc_q   <= skid_exc_d;
      skid_delay_q <= skid_delay_d;
    end
  end

`else

  assign up_ready  = ~main_valid_q | dn_ready;
  assign occupancy = {1'b0, main_valid_q};

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_exc_d   = main_exc_q;
    main_delay_d = main_delay_q;
    if (cancel) begin
      main_valid_d = 1'b0;
      main_data_d  = '0;
      main_exc_d   = 1'b0;
      main_delay_d = 1'b0;
    end else if (accept) begin
      main_valid_d = 1'b1;
      main_data_d  = in_data;
      main_exc_d   = up_exc;
      main_delay_d = in_delay;
    end else if (out_xfer) begin
      // Payload fields are left as-is after a drain with no refill.
      main_valid_d = 1'b0;
    end
  end

`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_exc_q   <= 1'b0;
      main_delay_q <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_exc_q   <= main_exc_d;
      main_delay_q <= main_delay_d;
    end
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline-boundary register, successor to the fixed 64-bit IF/ID latch. Intended for any stage boundary: IF/ID, ID/EX, EX/MEM.
- Carries a payload word, an exception tag and a delay-slot flag across the stage boundary under a valid/ready handshake.
- Supports flush on exception cancel, and payload masking when the upstream stage reports an exception.
- Optionally adds a second skid entry, so upstream ready becomes a registered signal.

Parameters:
- DATA_W, 64: payload width.
- KEEP_W, 32: number of low payload bits kept when the upstream exception tag is set (the PC field). Upper DATA_W-KEEP_W bits are zeroed. Legal range 0..DATA_W.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cancel  in  1  flush; clears all held entries at the next edge.
- up_valid  in  1  upstream has a word (stage-over).
- up_ready  out  1  this stage can accept a word.
- up_data  in  DATA_W  payload, {instr, pc} for IF/ID.
- up_exc  in  1  upstream exception (e.g. PC misaligned).
- up_jbr  in  1  the instruction currently downstream is a taken jump/branch, so the incoming word is a delay slot.
- dn_valid  out  1  held word present.
- dn_ready  in  1  downstream allow-in.
- dn_data  out  DATA_W  held payload.
- dn_exc  out  1  held exception tag.
- dn_delay  out  1  held word is a delay-slot instruction.
- occupancy  out  2  entries held: 0, 1 or 2.

Behaviour:
- Reset: dn_valid=0, dn_data=0, dn_exc=0, dn_delay=0, occupancy=0, skid entry cleared.
  - up_ready after reset: 1 in both modes.
- Transfers:
  - Accept when up_valid & up_ready at a rising edge.
  - Output transfer when dn_valid & dn_ready.
- Stored fields on accept:
  - data = up_exc ? {zeros(DATA_W-KEEP_W), up_data[KEEP_W-1:0]} : up_data.
  - exc = up_exc.
  - delay = up_jbr & ~up_exc.
- Priority, highest first: reset, cancel, transfers.
  - Cancel: all entries are invalidated; dn_data/dn_exc/dn_delay go to 0; occupancy goes to 0. Any same-cycle accept is discarded.
- Single-entry mode (SKID_BUF_EN undefined):
  - up_ready = ~dn_valid | dn_ready, combinational.
  - Latency up-to-down: 1 cycle.
  - Accept and output transfer in the same cycle: the new word replaces the old one, so back-to-back throughput is 1 word/cycle.
  - Held with dn_ready=0: outputs are stable, not re-sampled.
  - occupancy is 0 or 1.
- Output values:
  - dn_data/dn_exc/dn_delay are held unchanged after an output transfer that has no refill.
  - dn_valid drops to 0 after such a transfer.
- Full boundary: up_valid held with dn_ready=0 and entry full gives up_ready=0 and no accept. Payload is not overwritten.
- Empty boundary: dn_ready=1 with no entry has no effect.

Optional Feature:
- Macro: SKID_BUF_EN.
- Defined: adds a 2-entry buffer, main + skid.
  - up_ready = ~skid_valid, registered. There is no combinational path from dn_ready to up_ready.
  - When main is full, dn_ready=0 and an accept occurs, the word goes to skid; occupancy becomes 2 and up_ready drops next cycle.
  - When an output transfer occurs with skid full, skid moves to main at that edge.
  - Order is preserved: main is always the older entry.
  - Simultaneous accept and transfer with skid full cannot occur, because up_ready=0.
  - Cancel clears both entries.
  - Latency is still 1 cycle; throughput is 1 word/cycle.
- Undefined: single-entry behaviour as above; the skid register is absent.

Test Plan:
- Reset then accept: reset 2 cycles; up_valid=1, up_data=64'h0000_0020_8C01_0004, up_exc=0, up_jbr=0, dn_ready=1 -> next cycle dn_valid=1, dn_data=0000_0020_8C01_0004, dn_delay=0.
- Exception masking: up_exc=1, up_data=64'hDEAD_BEEF_0000_0042 -> dn_data=0000_0000_0000_0042, dn_exc=1, dn_delay=0 (even with up_jbr=1).
- Delay slot: up_jbr=1, up_exc=0, data A -> dn_delay=1. Next word with up_jbr=0 -> dn_delay=0.
- Backpressure: dn_ready=0 for 3 cycles while streaming A,B,C.
  - Single-entry: A is held, up_ready=0, B is not lost and is accepted after release.
  - SKID_BUF_EN: A in main, B in skid, occupancy=2, up_ready=0. Release gives A then B in order.
- Cancel vs accept: cancel=1 with up_valid=1 and occupancy=1 (2 with skid) -> next cycle dn_valid=0, occupancy=0, outputs 0. A word accepted in the following cycle appears normally.
- Reset mid-stall: occupancy nonzero, dn_ready=0, reset=1 for 1 cycle -> all outputs at reset values and up_ready=1 next cycle.
